// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared states, cause codes and parameter limits for reset_sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam logic [2:0] CAUSE_POR = 3'b001;
    localparam logic [2:0] CAUSE_SW  = 3'b010;
    localparam logic [2:0] CAUSE_WDT = 3'b100;

    localparam int MIN_HOLD_CYCLES = 2;
    localparam int MIN_STAGE_GAP   = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// rtl/reset_seq_timer.sv - terminal-count up-counter with synchronous clear
module reset_seq_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-domain reset release; RESET_SEQ_CAUSE_EN adds the reset_cause register
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2
) (
    input  logic                   clk,
    input  logic                   async_reset_in,
    input  logic                   sw_reset_req,
    input  logic                   wdt_reset_req,
    output logic [NUM_DOMAINS-1:0] reset_out,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic [2:0]             reset_cause
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CW-1:0] HOLD_TERM = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TERM  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOMAINS - 1);

    if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES below minimum");
    end
    if (STAGE_GAP < MIN_STAGE_GAP) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP below minimum");
    end
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
        $error("reset_sequencer: NUM_DOMAINS outside 1..8");
    end

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] term;
    logic          req;
    logic          timer_clear;
    logic          timer_tc;

    assign req         = sw_reset_req | wdt_reset_req;
    assign term        = (state == RELEASE) ? GAP_TERM : HOLD_TERM;
    // A held request pins the count at zero, so the hold only starts once it drops.
    assign timer_clear = req | timer_tc | (state == RUN);

    reset_seq_timer #(
        .W(CW)
    ) u_timer (
        .clk   (clk),
        .rst   (async_reset_in),
        .clear (timer_clear),
        .term  (term),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk or posedge async_reset_in) begin
        if (async_reset_in) begin
            state     <= ASSERT;
            idx       <= '0;
            reset_out <= '1;
            seq_busy  <= 1'b1;
            seq_done  <= 1'b0;
        end else if (req) begin
            state     <= ASSERT;
            idx       <= '0;
            reset_out <= '1;
            seq_busy  <= 1'b1;
            seq_done  <= 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    if (timer_tc) begin
                        state <= RELEASE;
                        idx   <= '0;
                    end
                end
                RELEASE: begin
                    if (timer_tc) begin
                        reset_out[idx] <= 1'b0;
                        // Lower domains are already free, so busy drops with the last one.
                        if (idx == LAST_IDX) begin
                            state    <= RUN;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    reset_out <= '0;
                    seq_busy  <= 1'b0;
                    seq_done  <= 1'b1;
                end
                default: begin
                    state     <= ASSERT;
                    idx       <= '0;
                    reset_out <= '1;
                    seq_busy  <= 1'b1;
                    seq_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_CAUSE_EN
    always_ff @(posedge clk or posedge async_reset_in) begin
        if (async_reset_in) begin
            reset_cause <= CAUSE_POR;
        end else if (wdt_reset_req) begin
            reset_cause <= CAUSE_WDT;
        end else if (sw_reset_req) begin
            reset_cause <= CAUSE_SW;
        end
    end
`else
    assign reset_cause = 3'b000;
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Takes the synchronised reset from the async reset controller plus two synchronous reset requests (software, watchdog). Releases NUM_DOMAINS reset domains one at a time, in index order, with a programmable gap between releases.
- Order: domain 0 first (clock/baud gen), then UART core, then RX/TX.
- Sits directly downstream of the async reset controller.
- Feeds every per-domain active-high reset in the UART top.

Parameters:
NUM_DOMAINS, 3, number of sequenced reset outputs (1..8)
HOLD_CYCLES, 4, cycles all domains stay asserted after the last reset cause clears (min 2)
STAGE_GAP, 2, cycles between successive domain releases (min 1)

Ports:
clk  input  1  system clock, all logic on posedge
async_reset_in  input  1  reset, asynchronous, active-high (driven by the async reset controller's reset_out)
sw_reset_req  input  1  synchronous software reset request, sampled each posedge
wdt_reset_req  input  1  synchronous watchdog reset request, sampled each posedge
reset_out  output  NUM_DOMAINS  per-domain active-high reset, bit k = domain k
seq_busy  output  1  high while any reset_out bit is high
seq_done  output  1  high in RUN (all domains released)
reset_cause  output  3  one-hot last reset cause (see Optional Feature)

Behaviour:
Async reset (async_reset_in=1):
- state=ASSERT, cnt=0, idx=0.
- reset_out=all 1s, seq_busy=1, seq_done=0.
- reset_cause=3'b001 (POR) when the feature is enabled.

States: ASSERT, RELEASE, RUN.
- ASSERT:
  - cnt increments each edge.
  - On the edge where cnt==HOLD_CYCLES-1: go to RELEASE, cnt=0, idx=0.
- RELEASE:
  - cnt increments each edge.
  - On the edge where cnt==STAGE_GAP-1: clear reset_out[idx].
  - If idx==NUM_DOMAINS-1: go to RUN on that same edge. Otherwise idx++ and cnt=0.
- RUN: hold. reset_out=0, seq_done=1, seq_busy=0.

Timing (edge 1 = first posedge with async_reset_in low):
- reset_out[k] falls at edge HOLD_CYCLES+(k+1)*STAGE_GAP.
- seq_done rises at the same edge as the last release.
- Once cleared, a bit stays 0 until the next reset cause.

Reset requests:
- sw_reset_req or wdt_reset_req high at a posedge, in any state: on that edge set reset_out=all 1s, state=ASSERT, cnt=0, idx=0, seq_done=0.
- A request held high keeps cnt at 0, so the hold time is extended. The hold count starts on the first edge with both requests low.
- A request during RELEASE re-asserts already-released domains on that same edge.

Other rules:
- seq_busy = |reset_out (registered-equivalent, no glitch from comb paths).
- Counter width $clog2(max(HOLD_CYCLES,STAGE_GAP)+1). cnt never wraps; the terminal compare always precedes overflow.
- Elaboration error if HOLD_CYCLES<2, STAGE_GAP<1, or NUM_DOMAINS outside 1..8.
- async_reset_in asserted mid-sequence: immediate return to the reset values above, no clock needed.

Optional Feature:
Macro RESET_SEQ_CAUSE_EN.
- Defined: reset_cause register, one-hot. 001=POR (async reset), 010=SW, 100=WDT.
  - Updated on the edge a request is accepted.
  - If both requests are high, WDT wins.
  - Value holds through RUN until the next cause.
- Undefined: register removed. reset_cause port remains, tied to 3'b000. All other behaviour identical.

Decomposition:
- Package reset_seq_pkg:
  - state enum (ASSERT=2'd0, RELEASE=2'd1, RUN=2'd2).
  - cause constants CAUSE_POR/CAUSE_SW/CAUSE_WDT.
  - Parameter-check constants MIN_HOLD_CYCLES=2 and MIN_STAGE_GAP=1.
- One sub-module: reset_seq_timer, a terminal-count up-counter with synchronous clear and terminal flag, shared by ASSERT and RELEASE.
- FSM, idx and reset_out register stay in reset_sequencer.

Test Plan:
- POR, defaults (4,2,3): drop async_reset_in before edge 1 → reset_out 111 through edge 5; 110 at edge 6; 100 at edge 8; 000 plus seq_done=1 at edge 10; reset_cause=001.
- sw_reset_req 1-cycle pulse in RUN at edge 20 → reset_out=111 at edge 20; seq_done=0; releases at edges 26/28/30; reset_cause=010.
- wdt_reset_req held high edges 40-45 → reset_out 111 throughout; first release at edge 45+6=51; reset_cause=100.
- sw and wdt both high on the same edge during RELEASE (after domain 0 freed) → reset_out back to 111 same edge; reset_cause=100 (WDT priority).
- async_reset_in pulsed mid-RELEASE, between clock edges → reset_out=111, seq_busy=1 immediately, before the next edge; full sequence repeats; reset_cause=001.
- Macro undefined, POR then sw request → reset_out timing identical to the first two scenarios; reset_cause constant 000.
